// File: rtl/sigmoid_backward_if.sv
// Streaming port bundle for the sigmoid backward unit: upstream (y, g) samples in,
// gradient samples out, each side with its own valid/ready pair.
interface sigmoid_backward_if #(
  parameter int DATA_W = 16
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] y_in;
  logic [DATA_W-1:0] g_in;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] grad_out;

  modport slave (
    input  in_valid, y_in, g_in, out_ready,
    output in_ready, out_valid, grad_out
  );

  modport master (
    output in_valid, y_in, g_in, out_ready,
    input  in_ready, out_valid, grad_out
  );
endinterface

// File: rtl/sigmoid_backward.sv
// Sigmoid backward pass: grad = g * y * (1 - y) in signed fixed point (1.0 = 1 << FRAC_W).
// Three-stage pipeline (clamp, derivative, gradient) under a single global stall.
module sigmoid_backward #(
  parameter int DATA_W = 16,
  parameter int FRAC_W = 9,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  sigmoid_backward_if.slave bus,
  output logic [CNT_W-1:0]  done_cnt
);

  localparam int YW = FRAC_W + 1;
  localparam int PW = DATA_W + YW + 1;
  localparam logic signed [DATA_W-1:0] ONE_S  = DATA_W'(32'd1 << FRAC_W);
  localparam logic        [YW-1:0]     ONE_U  = YW'(32'd1 << FRAC_W);
  localparam logic        [2*YW-1:0]   HALF_D = (2*YW)'(32'd1 << (FRAC_W - 1));
  localparam logic signed [PW-1:0]     HALF_G = PW'(32'd1 << (FRAC_W - 1));

  function automatic logic [YW-1:0] clamp_y(input logic signed [DATA_W-1:0] y);
    logic [YW-1:0] r;
    if (y[DATA_W-1]) begin
      r = '0;
    end else if (y > ONE_S) begin
      r = ONE_U;
    end else begin
      r = y[YW-1:0];
    end
    return r;
  endfunction

  // y*(1-y) peaks at 0.25, so the rounded result always fits in YW bits.
  function automatic logic [YW-1:0] deriv(input logic [YW-1:0] yc, input logic [YW-1:0] om);
    logic [2*YW-1:0] p;
    p = yc * om;
    p = p + HALF_D;
    return YW'(p >> FRAC_W);
  endfunction

  function automatic logic [DATA_W-1:0] gradient(input logic signed [DATA_W-1:0] g,
                                                 input logic [YW-1:0] d);
    logic signed [PW-1:0] p;
    p = $signed(g) * $signed({1'b0, d});
    p = (p + HALF_G) >>> FRAC_W;
    return DATA_W'(p);
  endfunction

  logic              v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
  logic [YW-1:0]     yc_q, yc_d, om_q, om_d, d_q, d_d;
  logic [DATA_W-1:0] g1_q, g1_d, g2_q, g2_d, grad_q, grad_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              adv_s;
  logic [YW-1:0]     yc_s;

  assign adv_s         = ~v3_q | bus.out_ready;
  assign yc_s          = clamp_y(bus.y_in);
  assign bus.in_ready  = adv_s;
  assign bus.out_valid = v3_q;
  assign bus.grad_out  = grad_q;
  assign done_cnt      = cnt_q;

  // Next-state: every stage shifts together when the output side can move.
  always_comb begin
    v1_d   = v1_q;
    v2_d   = v2_q;
    v3_d   = v3_q;
    yc_d   = yc_q;
    om_d   = om_q;
    g1_d   = g1_q;
    d_d    = d_q;
    g2_d   = g2_q;
    grad_d = grad_q;
    cnt_d  = cnt_q;
    if (adv_s) begin
      v1_d   = bus.in_valid;
      yc_d   = yc_s;
      om_d   = ONE_U - yc_s;
      g1_d   = bus.g_in;
      v2_d   = v1_q;
      d_d    = deriv(yc_q, om_q);
      g2_d   = g1_q;
      v3_d   = v2_q;
      grad_d = gradient(g2_q, d_q);
    end else begin
      v1_d = v1_q;
    end
    if (v3_q && bus.out_ready) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Pipeline and counter state; reset discards everything in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v1_q   <= 1'b0;
      v2_q   <= 1'b0;
      v3_q   <= 1'b0;
      yc_q   <= '0;
      om_q   <= '0;
      g1_q   <= '0;
      d_q    <= '0;
      g2_q   <= '0;
      grad_q <= '0;
      cnt_q  <= '0;
    end else begin
      v1_q   <= v1_d;
      v2_q   <= v2_d;
      v3_q   <= v3_d;
      yc_q   <= yc_d;
      om_q   <= om_d;
      g1_q   <= g1_d;
      d_q    <= d_d;
      g2_q   <= g2_d;
      grad_q <= grad_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: tb/tb_sigmoid_backward.sv
// Directed bench for sigmoid_backward: single-sample vectors, back-to-back stream,
// output stall and mid-stream reset, all against hand-computed gradients.
module tb_sigmoid_backward;

  localparam int DATA_W = 16;
  localparam int FRAC_W = 9;
  localparam int CNT_W  = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [CNT_W-1:0] done_cnt;

  sigmoid_backward_if #(.DATA_W(DATA_W)) bus ();

  sigmoid_backward #(.DATA_W(DATA_W), .FRAC_W(FRAC_W), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus.slave),
    .done_cnt (done_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  logic [DATA_W-1:0] got_q[$];
  int                got_cyc_q[$];

  // Single-sample vectors: y, g, expected grad (hand computed).
  logic [15:0] y_v [0:9] = '{16'h0100, 16'h0100, 16'h0080, 16'h0300, 16'hFF00,
                             16'h0200, 16'h0180, 16'h0100, 16'h0100, 16'h0000};
  logic [15:0] g_v [0:9] = '{16'h0200, 16'hFE00, 16'h0400, 16'h0200, 16'h0200,
                             16'h0200, 16'h7FFF, 16'hFFFD, 16'h0003, 16'h0400};
  logic [15:0] e_v [0:9] = '{16'h0080, 16'hFF80, 16'h00C0, 16'h0000, 16'h0000,
                             16'h0000, 16'h1800, 16'hFFFF, 16'h0001, 16'h0000};

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor: inputs settle at the falling edge, so a handshake is visible just after it.
  always @(negedge clk) begin
    #1;
    if (rst && bus.out_valid && bus.out_ready) begin
      got_q.push_back(bus.grad_out);
      got_cyc_q.push_back(cyc);
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic run_one(input logic [15:0] y, input logic [15:0] g,
                         input logic [15:0] exp, input string tag);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.y_in     = y;
    bus.g_in     = g;
    check_eq({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    @(posedge clk);
    #1 check_eq({tag, "_early"}, 32'(bus.out_valid), 32'd0);
    @(posedge clk);
    #1 check_eq({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
    check_eq({tag, "_grad"}, 32'(bus.grad_out), 32'(exp));
    @(posedge clk);
    #1 check_eq({tag, "_drain"}, 32'(bus.out_valid), 32'd0);
  endtask

  initial begin
    int idx;
    int stall_cycles;
    int n_before;
    bit prev_stall;
    logic [DATA_W-1:0] prev_g;

    bus.in_valid  = 1'b0;
    bus.y_in      = '0;
    bus.g_in      = '0;
    bus.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check_eq("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check_eq("rst_grad", 32'(bus.grad_out), 32'd0);
    check_eq("rst_done_cnt", 32'(done_cnt), 32'd0);
    check_eq("rst_in_ready", 32'(bus.in_ready), 32'd1);
    rst = 1'b1;

    // Directed single samples, including clamp and rounding corners.
    for (int i = 0; i < 10; i++) begin
      run_one(y_v[i], g_v[i], e_v[i], $sformatf("vec%0d", i));
      if (i == 0) check_eq("first_done_cnt", 32'(done_cnt), 32'd1);
    end
    check_eq("vec_done_cnt", 32'(done_cnt), 32'd10);

    // Back-to-back stream of 8: y=0.5 so grad = g/4 exactly.
    do_reset();
    got_q.delete();
    got_cyc_q.delete();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.y_in     = 16'h0100;
      bus.g_in     = 16'((i + 1) << 9);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (6) @(negedge clk);
    check_eq("b2b_count", 32'(got_q.size()), 32'd8);
    for (int i = 0; i < 8 && i < got_q.size(); i++) begin
      check_eq($sformatf("b2b_val%0d", i), 32'(got_q[i]), 32'((i + 1) * 128));
      if (i > 0) check_eq($sformatf("b2b_gap%0d", i), 32'(got_cyc_q[i] - got_cyc_q[i-1]), 32'd1);
    end
    check_eq("b2b_done_cnt", 32'(done_cnt), 32'd8);

    // Output stall for 5 cycles mid-stream: y=0.25 so d=0x60, grad = 0x60*(i+1).
    do_reset();
    got_q.delete();
    got_cyc_q.delete();
    idx = 0;
    stall_cycles = 0;
    prev_stall = 1'b0;
    prev_g = '0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      bus.out_ready = !(c >= 4 && c < 9);
      bus.in_valid  = (idx < 6);
      bus.y_in      = 16'h0080;
      bus.g_in      = 16'((idx + 1) << 9);
      #1;
      if (bus.out_valid && !bus.out_ready) begin
        stall_cycles++;
        check_eq("stall_in_ready", 32'(bus.in_ready), 32'd0);
        if (prev_stall) check_eq("stall_hold", 32'(bus.grad_out), 32'(prev_g));
        prev_stall = 1'b1;
        prev_g = bus.grad_out;
      end else begin
        prev_stall = 1'b0;
      end
      if (bus.in_valid && bus.in_ready) idx++;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    check_eq("stall_len", 32'(stall_cycles), 32'd5);
    check_eq("stall_count", 32'(got_q.size()), 32'd6);
    for (int i = 0; i < 6 && i < got_q.size(); i++) begin
      check_eq($sformatf("stall_val%0d", i), 32'(got_q[i]), 32'((i + 1) * 96));
    end
    check_eq("stall_done_cnt", 32'(done_cnt), 32'd6);

    // Reset with three samples in flight.
    got_q.delete();
    got_cyc_q.delete();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.y_in     = 16'h0100;
      bus.g_in     = 16'((k + 1) << 9);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    check_eq("flight_valid", 32'(bus.out_valid), 32'd1);
    n_before = got_q.size();
    rst = 1'b0;
    #1;
    check_eq("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    check_eq("midrst_done_cnt", 32'(done_cnt), 32'd0);
    check_eq("midrst_grad", 32'(bus.grad_out), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (4) @(negedge clk);
    check_eq("midrst_no_output", 32'(got_q.size()), 32'(n_before));
    run_one(16'h0100, 16'h0200, 16'h0080, "post_rst");
    check_eq("post_rst_done_cnt", 32'(done_cnt), 32'd1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
